// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and
// instruction memory. The fetch stage is the master.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: holds the PC, fetches one instruction at a
// time over the req/ack bus, presents it until retirement, then advances the
// PC either sequentially or to the branch target. Counts retired instructions.
module instruction_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        imem,
    input  logic                       stall,
    input  logic                       branch_eq,
    input  logic                       branch_ne,
    input  logic                       zero,
    input  logic signed [31:0]         branch_offset,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    output logic [31:0]                retired_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;

    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic        instrValidReg;
    logic [31:0] retiredReg;
    logic        fetchReq;
    logic        ackTaken;
    logic        retire;
    logic [31:0] seqPc;
    logic [31:0] nextPc;

    // Taken when BEQ sees equality or BNE sees inequality; both set means taken.
    function automatic logic branchTaken(input logic beq, input logic bne, input logic z);
        return (beq & z) | (bne & ~z);
    endfunction

    // Word offset scaled to bytes; the shift drops offset bits [31:30] (mod 2^32).
    function automatic logic [31:0] branchTarget(input logic [31:0] base,
                                                 input logic [31:0] offset);
        logic [31:0] byteOffset;
        byteOffset = offset << 2;
        return base + byteOffset;
    endfunction

    assign seqPc    = pcReg + 32'd4;
    assign ackTaken = (state == FETCH) && imem.imem_ack;
    assign retire   = (state == VALID) && !stall;
    assign nextPc   = branchTaken(branch_eq, branch_ne, zero)
                      ? branchTarget(seqPc, branch_offset) : seqPc;

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and request decode; request depends on state only.
    always_comb begin
        nextState = state;
        fetchReq  = 1'b0;
        case (state)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                fetchReq = 1'b1;
                if (imem.imem_ack) begin
                    nextState = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    nextState = FETCH;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // PC, instruction register and retirement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg         <= PC_RESET;
            instrReg      <= 32'd0;
            instrValidReg <= 1'b0;
            retiredReg    <= 32'd0;
        end else begin
            if (ackTaken) begin
                instrReg      <= imem.imem_rdata;
                instrValidReg <= 1'b1;
            end
            if (retire) begin
                pcReg         <= nextPc;
                instrValidReg <= 1'b0;
                retiredReg    <= retiredReg + 32'd1;
            end
        end
    end

    assign imem.imem_req  = fetchReq;
    assign imem.imem_addr = pcReg;
    assign instr          = instrReg;
    assign instr_valid    = instrValidReg;
    assign pc             = pcReg;
    assign pc_plus4       = seqPc;
    assign retired_count  = retiredReg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, random
// instruction stream against a transaction-level PC model, reset and
// wrap-around corner cases.
module tb_instruction_fetch;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_eq = 1'b0;
    logic        branch_ne = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] branch_offset = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired_count;

    int   ackDelay = 0;
    logic ackForce = 1'b0;
    int   waitCnt = 0;
    int   cyc = 0;
    int   nCmp = 0;
    int   nFail = 0;

    logic [31:0] modelPc;
    logic [31:0] modelCount;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h2008_0005 ^ ((a - 32'h0040_0000) << 4);
    endfunction

    instruction_fetch_if bus();
    assign bus.imem_ack   = ackForce | (bus.imem_req & (waitCnt >= ackDelay));
    assign bus.imem_rdata = memWord(bus.imem_addr);

    always @(posedge clk) begin
        waitCnt <= (bus.imem_req && !bus.imem_ack) ? waitCnt + 1 : 0;
        cyc     <= cyc + 1;
    end

    instruction_fetch #(.PC_RESET(PC_RESET)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (bus),
        .stall         (stall),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .branch_offset (branch_offset),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .retired_count (retired_count)
    );

    // Second instance for wrap-around at the top of the address space.
    logic        rst2 = 1'b1;
    logic [31:0] instr2;
    logic        instrValid2;
    logic [31:0] pc2;
    logic [31:0] pcPlus4_2;
    logic [31:0] count2;

    instruction_fetch_if bus2();
    assign bus2.imem_ack   = bus2.imem_req;
    assign bus2.imem_rdata = 32'h0000_0020;

    instruction_fetch #(.PC_RESET(32'hFFFF_FFFC)) dutWrap (
        .clk           (clk),
        .reset         (rst2),
        .imem          (bus2),
        .stall         (1'b0),
        .branch_eq     (1'b0),
        .branch_ne     (1'b0),
        .zero          (1'b0),
        .branch_offset (32'd0),
        .instr         (instr2),
        .instr_valid   (instrValid2),
        .pc            (pc2),
        .pc_plus4      (pcPlus4_2),
        .retired_count (count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randBranch();
        branch_eq     = 1'($urandom_range(0, 1));
        branch_ne     = 1'($urandom_range(0, 1));
        zero          = 1'($urandom_range(0, 1));
        branch_offset = $urandom;
    endtask

    // Runs one instruction, starting in its first FETCH cycle.
    task automatic runInstr(input int delay, input int stallCyc, input logic beq,
                            input logic bne, input logic z, input logic [31:0] off);
        logic taken;
        ackDelay = delay;
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, modelPc);
        chk("fetch_pc_plus4", pc_plus4, modelPc + 32'd4);
        chk("fetch_valid", 32'(instr_valid), 32'd0);
        randBranch();
        for (int k = 0; k < delay; k++) begin
            tick();
            chk("wait_req", 32'(bus.imem_req), 32'd1);
            chk("wait_addr", bus.imem_addr, modelPc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            randBranch();
        end
        tick();
        chk("valid", 32'(instr_valid), 32'd1);
        chk("instr", instr, memWord(modelPc));
        chk("valid_req", 32'(bus.imem_req), 32'd0);
        for (int s = 0; s < stallCyc; s++) begin
            stall    = 1'b1;
            ackForce = 1'($urandom_range(0, 1));
            randBranch();
            tick();
            chk("stall_pc", pc, modelPc);
            chk("stall_instr", instr, memWord(modelPc));
            chk("stall_count", retired_count, modelCount);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall         = 1'b0;
        ackForce      = 1'b0;
        branch_eq     = beq;
        branch_ne     = bne;
        zero          = z;
        branch_offset = off;
        tick();
        taken      = (beq && z) || (bne && !z);
        modelPc    = modelPc + 32'd4 + (taken ? off * 32'd4 : 32'd0);
        modelCount = modelCount + 32'd1;
        chk("retire_pc", pc, modelPc);
        chk("retire_count", retired_count, modelCount);
        chk("retire_valid", 32'(instr_valid), 32'd0);
    endtask

    typedef struct {
        int          delay;
        int          stallCyc;
        logic        beq;
        logic        bne;
        logic        z;
        logic [31:0] off;
        logic [31:0] pcAddr;
        logic [31:0] expNext;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycStart;
        logic [31:0] rOff;

        tbl[0]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0000, 32'h0040_0004};
        tbl[1]  = '{0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0040_0004, 32'h0040_0008};
        tbl[2]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_000C};
        tbl[3]  = '{0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0040_000C, 32'h0040_0010};
        tbl[4]  = '{0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0040_0010, 32'h0040_0004};
        tbl[5]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0004, 32'h0040_0008};
        tbl[6]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_000C};
        tbl[7]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_000C, 32'h0040_0010};
        tbl[8]  = '{0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0040_0010, 32'h0040_0014};
        tbl[9]  = '{0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0040_0014, 32'h0040_0010};
        tbl[10] = '{0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0040_0010, 32'h0040_0020};
        tbl[11] = '{1, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'h0040_0020, 32'h0040_0028};
        tbl[12] = '{3, 5, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0028, 32'h0040_002C};
        tbl[13] = '{2, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 32'h0040_002C, 32'h0040_0030};
        tbl[14] = '{0, 2, 1'b1, 1'b0, 1'b1, 32'hC000_0001, 32'h0040_0030, 32'h0040_0038};

        // Reset held for three cycles.
        repeat (3) tick();
        chk("reset_req", 32'(bus.imem_req), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_count", retired_count, 32'd0);
        chk("reset_pc", pc, PC_RESET);

        reset      = 1'b0;
        modelPc    = PC_RESET;
        modelCount = 32'd0;
        chk("release_req", 32'(bus.imem_req), 32'd0);
        tick();

        // Directed vectors.
        cycStart = cyc;
        for (int i = 0; i < 15; i++) begin
            chk("table_pc", bus.imem_addr, tbl[i].pcAddr);
            runInstr(tbl[i].delay, tbl[i].stallCyc, tbl[i].beq, tbl[i].bne,
                     tbl[i].z, tbl[i].off);
            chk("table_next", pc, tbl[i].expNext);
            if (i == 3) begin
                chk("seq_cycles", 32'(cyc - cycStart), 32'd8);
                chk("seq_count", retired_count, 32'd4);
            end
        end

        // Random instruction stream.
        for (int i = 0; i < 40; i++) begin
            rOff = ($urandom_range(0, 1) == 1) ? $urandom
                                              : (32'($urandom_range(0, 15)) - 32'd8);
            runInstr($urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rOff);
        end

        // Reset while a fetch is pending; ack arrives in the reset cycle.
        ackDelay = 5;
        tick();
        chk("midreset_pending", 32'(bus.imem_req), 32'd1);
        reset    = 1'b1;
        ackForce = 1'b1;
        tick();
        reset    = 1'b0;
        ackForce = 1'b0;
        ackDelay = 0;
        chk("midreset_valid", 32'(instr_valid), 32'd0);
        chk("midreset_pc", pc, PC_RESET);
        chk("midreset_count", retired_count, 32'd0);
        chk("midreset_instr", instr, 32'd0);
        chk("midreset_req", 32'(bus.imem_req), 32'd0);
        modelPc    = PC_RESET;
        modelCount = 32'd0;
        tick();
        runInstr(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Wrap-around from the last word of the address space.
        rst2 = 1'b0;
        tick();
        chk("wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pcPlus4_2, 32'd0);
        tick();
        chk("wrap_valid", 32'(instrValid2), 32'd1);
        chk("wrap_instr", instr2, 32'h0000_0020);
        tick();
        chk("wrap_next_addr", bus2.imem_addr, 32'd0);
        chk("wrap_req", 32'(bus2.imem_req), 32'd1);
        chk("wrap_count", count2, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the MIPS datapath. Holds the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents the current instruction, whose bits [31:26] drive the control unit's OP input. On retirement it computes the next PC from the control unit's BranchEQ/BranchNE outputs and the ALU Zero flag. It also counts retired instructions.

## Interface
- PC_RESET, 32'h0040_0000, PC value loaded on reset (word aligned)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request, high while waiting for memory
- imem_addr  output  32  fetch address, equals pc
- imem_ack  input  1  memory has returned data for the current request
- imem_rdata  input  32  instruction word, sampled when imem_req & imem_ack
- stall  input  1  downstream cannot accept retirement this cycle
- branch_eq  input  1  BranchEQ from control unit for the current instruction
- branch_ne  input  1  BranchNE from control unit for the current instruction
- zero  input  1  ALU Zero flag for the current instruction
- branch_offset  input  32  sign-extended immediate of the current instruction
- instr  output  32  current instruction register
- instr_valid  output  1  instr holds a valid instruction
- pc  output  32  address of the current/pending instruction
- pc_plus4  output  32  pc + 4, combinational
- retired_count  output  32  number of retired instructions

## Operation
- FSM states: IDLE, FETCH, VALID.
- Reset (any state, any cycle): state=IDLE, pc=PC_RESET, instr=0, instr_valid=0, retired_count=0. imem_req=0. Any outstanding request is abandoned and a late ack is ignored, because ack is only sampled in FETCH.
- IDLE: imem_req=0. Next state is unconditionally FETCH.
- FETCH: imem_req=1, imem_addr=pc, held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, next state is VALID.
  - Otherwise remain in FETCH.
- VALID: imem_req=0, instr_valid=1.
  - stall=1: hold all state.
  - stall=0: the instruction retires.
    - pc<=next_pc, instr_valid<=0, retired_count<=retired_count+1, next state is FETCH.
    - instr keeps its old value, but it is don't-care while instr_valid=0.
- imem_ack outside FETCH is ignored. Branch/zero/offset inputs are only used in VALID with stall=0.
- taken = (branch_eq & zero) | (branch_ne & ~zero). If both branch_eq and branch_ne are high, taken=1 regardless of zero.
- next_pc = taken ? pc_plus4 + (branch_offset << 2) : pc_plus4.
- Arithmetic is 32-bit, modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0. A shifted offset discards bits [31:30] of branch_offset.
- pc[1:0] is always 2'b00.

## Timing
- Reset deasserted at cycle 0 gives IDLE in cycle 0 and imem_req=1 from cycle 1.
- Zero-wait memory: ack in the same cycle as req gives instr_valid=1 the next cycle.
- With no stalls and zero-wait memory, the sequence is FETCH, VALID, FETCH, … which is 2 cycles per instruction.
- The memory latency of N wait cycles adds N cycles to FETCH.
- Retirement takes effect at the edge ending a VALID&!stall cycle. pc updates and the new request starts in the following cycle.
- All outputs except pc_plus4, imem_req and imem_addr are registered. imem_req, imem_addr and pc_plus4 decode combinationally from state/pc only, not from inputs.

## Test plan
- Reset/startup: hold reset 3 cycles, then release with imem_ack tied to imem_req and rdata=32'h2008_0005 (addi).
  - Required: imem_req=0 in the release cycle, =1 the next cycle with imem_addr=32'h0040_0000.
  - Required: instr=32'h2008_0005 with instr_valid=1 one cycle later.
- Sequential fetch: zero-wait memory, no branches, 4 instructions.
  - Required: imem_addr sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
  - Required: retired_count=4, 2 cycles per instruction.
- Branches:
  - pc=0x00400010, branch_eq=1, zero=1, offset=32'hFFFF_FFFC: next imem_addr=0x00400004.
  - Same inputs with zero=0: next imem_addr=0x00400014.
  - branch_ne=1, zero=0, offset=3: next imem_addr=0x00400020.
- Stall and wait states:
  - Delay ack 3 cycles: imem_addr stays stable and instr_valid=0 throughout.
  - Then hold stall=1 for 5 cycles in VALID: pc, instr and retired_count are unchanged and no new request is issued.
- Wrap-around: PC_RESET=32'hFFFF_FFFC, retire one non-branch instruction. Required: next imem_addr=0.
- Reset mid-operation:
  - Assert reset while in FETCH with ack pending; deliver ack in the reset cycle.
  - Required: ack is ignored, pc=PC_RESET, instr_valid=0, retired_count=0.
